mmu_arbiter_wrr: RTL and testbench
==================================

// Module: mmu_arbiter_wrr
// PURPOSE
//  Parametrised successor of the per-region host DMA request arbiter. Merges N_CH region request
//  queues onto one DMA request port plus a mux-ordering port, using weighted round-robin with
//  per-channel outstanding-transfer credits. Sits between the region MMUs and the host DMA.
// PARAMETERS
//  N_CH      4   number of request channels (regions), 1..16
//  REQ_BITS  96  width of one request descriptor
//  LEN_LSB   64  bit offset of the LEN_BITS length field inside a descriptor
//  LEN_BITS  28  length field width
//  W_BITS    4   per-channel weight width
//  MAX_OUT   8   max outstanding grants per channel (credit ceiling)
// PORTS
//  aclk          in   1                clock
//  aresetn       in   1                reset, synchronous, active-low
//  s_req_valid   in   N_CH             per-channel request valid
//  s_req_ready   out  N_CH             per-channel request ready
//  s_req_data    in   N_CH*REQ_BITS    per-channel descriptor, channel i at [i*REQ_BITS +: REQ_BITS]
//  cnfg_weight   in   N_CH*W_BITS      per-channel weight (consecutive grants), sampled at burst start
//  xfer_done     in   N_CH             one-cycle pulse per completed transfer, returns one credit
//  m_req_valid   out  1                merged request valid
//  m_req_ready   in   1                merged request ready
//  m_req_data    out  REQ_BITS         merged request descriptor
//  m_mux_valid   out  1                ordering entry valid
//  m_mux_ready   in   1                ordering entry ready
//  m_mux_id      out  clog2(N_CH)      channel id of granted request (width min 1)
//  m_mux_len     out  LEN_BITS         length of granted request
//  busy_out      out  N_CH             per-channel outstanding count nonzero
// BEHAVIOUR
//  - Reset: all valids/readies 0, data/id/len 0, pointer=0, burst count=0, all credit counters 0.
//  - Eligible(i) = s_req_valid[i] && outcnt[i] < MAX_OUT.
//  - Output slots: m_req and m_mux are independent single registers. Slot free = !valid || ready.
//    Grant occurs only in a cycle where both slots are free and at least one channel is eligible.
//  - Grant: s_req_ready[g]=1 combinationally for exactly one g in that cycle; next cycle
//    m_req_valid=1 with s_req_data[g], m_mux_valid=1 with id=g, len=data[LEN_LSB+:LEN_BITS].
//    Latency input-accept -> output valid: 1 cycle. Full throughput 1 grant/cycle when both ready.
//  - Each valid holds until its own ready; data stable while valid && !ready (AXIS rules).
//  - Selection, two-state FSM:
//    SCAN:  pick first eligible channel at or after pointer (wrap modulo N_CH); load
//           burst = max(cnfg_weight[g],1)-1; if burst==0 pointer<=g+1 (wrap) and stay SCAN,
//           else pointer<=g, go HOLD.
//    HOLD:  if Eligible(pointer) and grant possible: grant pointer, burst--, at burst==0 after
//           grant pointer<=pointer+1, go SCAN. If pointer not eligible: advance pointer, go SCAN
//           without granting this cycle. If slots busy: stay, nothing changes.
//  - Credits: outcnt[i] +1 on grant of i, -1 on xfer_done[i]; simultaneous -> unchanged.
//    xfer_done on outcnt==0 is ignored (saturate at 0). outcnt width clog2(MAX_OUT+1).
//  - Weight change mid-burst takes effect at the next burst start only.
//  - N_CH==1: pointer fixed 0, m_mux_id=0; weights/credits still apply.
//  - Reset mid-operation: pending output entries dropped, credits cleared; no grant in reset cycle.
// TESTING
//  1. Reset: hold aresetn=0 3 cycles with all s_req_valid=1 -> no s_req_ready, all outputs 0.
//  2. N_CH=4, weights all 1, all valid, sinks always ready -> grant order 0,1,2,3,0,...; 1/cycle.
//  3. Weights {3,1,1,1} -> mux ids 0,0,0,1,2,3,0,0,0; m_mux_len equals injected lengths.
//  4. MAX_OUT=8, ch0 only, no xfer_done -> exactly 8 grants then stall; one xfer_done -> 1 more.
//  5. Grant and xfer_done same cycle on ch2 at outcnt=5 -> outcnt stays 5.
//  6. m_mux_ready=0, m_req_ready=1 -> at most 1 request issued, stall until mux drains; no loss.

Source files
------------

// File: rtl/mmu_arbiter_wrr.sv
// rtl/mmu_arbiter_wrr.sv - weighted round-robin merge of per-region DMA request queues
// Grants are credit-limited per channel and land in two independent single-entry output slots.
module mmu_arbiter_wrr #(
   parameter int N_CH     = 4,
   parameter int REQ_BITS = 96,
   parameter int LEN_LSB  = 64,
   parameter int LEN_BITS = 28,
   parameter int W_BITS   = 4,
   parameter int MAX_OUT  = 8
) (
   input  logic                                      aclk,
   input  logic                                      aresetn,
   input  logic [N_CH-1:0]                           s_req_valid,
   output logic [N_CH-1:0]                           s_req_ready,
   input  logic [N_CH*REQ_BITS-1:0]                  s_req_data,
   input  logic [N_CH*W_BITS-1:0]                    cnfg_weight,
   input  logic [N_CH-1:0]                           xfer_done,
   output logic                                      m_req_valid,
   input  logic                                      m_req_ready,
   output logic [REQ_BITS-1:0]                       m_req_data,
   output logic                                      m_mux_valid,
   input  logic                                      m_mux_ready,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] m_mux_id,
   output logic [LEN_BITS-1:0]                       m_mux_len,
   output logic [N_CH-1:0]                           busy_out
);

   localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   typedef enum logic {ST_SCAN, ST_HOLD} state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [W_BITS-1:0]    burst_q, burst_d;
   logic [CNT_W-1:0]     outcnt_q [N_CH];
   logic [CNT_W-1:0]     outcnt_d [N_CH];
   logic                 m_req_valid_q, m_req_valid_d;
   logic [REQ_BITS-1:0]  m_req_data_q, m_req_data_d;
   logic                 m_mux_valid_q, m_mux_valid_d;
   logic [ID_W-1:0]      m_mux_id_q, m_mux_id_d;
   logic [LEN_BITS-1:0]  m_mux_len_q, m_mux_len_d;

   logic [N_CH-1:0]      elig;
   logic [2*N_CH-1:0]    elig_rot;
   logic                 slots_free;
   logic                 scan_found;
   int                   scan_off;
   int                   scan_sum;
   logic [ID_W-1:0]      scan_idx;
   logic [ID_W-1:0]      scan_idx_inc;
   logic [ID_W-1:0]      ptr_inc;
   logic [W_BITS-1:0]    scan_w;
   logic [W_BITS-1:0]    scan_burst;
   logic                 grant_en;
   logic [ID_W-1:0]      grant_idx;
   logic [N_CH-1:0]      grant_oh;
   logic [REQ_BITS-1:0]  sel_data;
   logic                 cr_inc;
   logic                 cr_dec;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_CH; i++) begin
         elig[i] = s_req_valid[i] && (outcnt_q[i] < CNT_W'(MAX_OUT));
      end
      slots_free = (!m_req_valid_q || m_req_ready) && (!m_mux_valid_q || m_mux_ready);

      // Rotate so bit 0 is the pointer channel; lowest set bit is the next in ring order.
      elig_rot   = {elig, elig} >> ptr_q;
      scan_found = 1'b0;
      scan_off   = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (elig_rot[k]) begin
            scan_found = 1'b1;
            scan_off   = k;
         end
      end
      scan_sum = int'(ptr_q) + scan_off;
      if (scan_sum >= N_CH) begin
         scan_sum = scan_sum - N_CH;
      end
      scan_idx     = ID_W'(scan_sum);
      scan_idx_inc = (scan_idx == ID_W'(N_CH - 1)) ? '0 : scan_idx + 1'b1;
      ptr_inc      = (ptr_q == ID_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;

      scan_w = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ID_W'(i) == scan_idx) begin
            scan_w = cnfg_weight[i*W_BITS +: W_BITS];
         end
      end
      scan_burst = (scan_w == '0) ? '0 : scan_w - 1'b1;

      state_d   = state_q;
      ptr_d     = ptr_q;
      burst_d   = burst_q;
      grant_en  = 1'b0;
      grant_idx = '0;
      case (state_q)
         ST_SCAN: begin
            if (slots_free && scan_found) begin
               grant_en  = 1'b1;
               grant_idx = scan_idx;
               if (scan_burst == '0) begin
                  ptr_d = scan_idx_inc;
               end else begin
                  ptr_d   = scan_idx;
                  burst_d = scan_burst;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!elig_rot[0]) begin
               ptr_d   = ptr_inc;
               state_d = ST_SCAN;
            end else if (slots_free) begin
               grant_en  = 1'b1;
               grant_idx = ptr_q;
               burst_d   = burst_q - 1'b1;
               if (burst_q == W_BITS'(1)) begin
                  ptr_d   = ptr_inc;
                  state_d = ST_SCAN;
               end
            end
         end
         default: state_d = ST_SCAN;
      endcase
      if (!aresetn) begin
         grant_en = 1'b0;
      end

      grant_oh = '0;
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         grant_oh[i] = grant_en && (ID_W'(i) == grant_idx);
         if (grant_oh[i]) begin
            sel_data = s_req_data[i*REQ_BITS +: REQ_BITS];
         end
      end

      cr_inc = 1'b0;
      cr_dec = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         cr_inc      = grant_oh[i];
         cr_dec      = xfer_done[i] && (outcnt_q[i] != '0);
         outcnt_d[i] = outcnt_q[i];
         if (cr_inc && !cr_dec) begin
            outcnt_d[i] = outcnt_q[i] + 1'b1;
         end else if (!cr_inc && cr_dec) begin
            outcnt_d[i] = outcnt_q[i] - 1'b1;
         end
      end

      m_req_valid_d = m_req_valid_q && !m_req_ready;
      m_req_data_d  = m_req_data_q;
      m_mux_valid_d = m_mux_valid_q && !m_mux_ready;
      m_mux_id_d    = m_mux_id_q;
      m_mux_len_d   = m_mux_len_q;
      if (grant_en) begin
         m_req_valid_d = 1'b1;
         m_req_data_d  = sel_data;
         m_mux_valid_d = 1'b1;
         m_mux_id_d    = grant_idx;
         m_mux_len_d   = sel_data[LEN_LSB +: LEN_BITS];
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= ST_SCAN;
         ptr_q         <= '0;
         burst_q       <= '0;
         m_req_valid_q <= 1'b0;
         m_req_data_q  <= '0;
         m_mux_valid_q <= 1'b0;
         m_mux_id_q    <= '0;
         m_mux_len_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            outcnt_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         burst_q       <= burst_d;
         m_req_valid_q <= m_req_valid_d;
         m_req_data_q  <= m_req_data_d;
         m_mux_valid_q <= m_mux_valid_d;
         m_mux_id_q    <= m_mux_id_d;
         m_mux_len_q   <= m_mux_len_d;
         for (int i = 0; i < N_CH; i++) begin
            outcnt_q[i] <= outcnt_d[i];
         end
      end
   end

   always_comb begin
      busy_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         busy_out[i] = (outcnt_q[i] != '0);
      end
   end

   assign s_req_ready = grant_oh;
   assign m_req_valid = m_req_valid_q;
   assign m_req_data  = m_req_data_q;
   assign m_mux_valid = m_mux_valid_q;
   assign m_mux_id    = m_mux_id_q;
   assign m_mux_len   = m_mux_len_q;

endmodule

// File: tb/tb_mmu_arbiter_wrr.sv
// tb/tb_mmu_arbiter_wrr.sv - randomized scoreboard bench for mmu_arbiter_wrr
// Reference model tracks ring pointer, remaining burst, credits and slot occupancy as plain ints.
module tb_mmu_arbiter_wrr;
   localparam int N  = 4;
   localparam int RB = 96;
   localparam int LL = 64;
   localparam int LB = 28;
   localparam int WB = 4;
   localparam int MO = 8;

   logic              aclk;
   logic              aresetn;
   logic [N-1:0]      s_req_valid;
   logic [N-1:0]      s_req_ready;
   logic [N*RB-1:0]   s_req_data;
   logic [N*WB-1:0]   cnfg_weight;
   logic [N-1:0]      xfer_done;
   logic              m_req_valid;
   logic              m_req_ready;
   logic [RB-1:0]     m_req_data;
   logic              m_mux_valid;
   logic              m_mux_ready;
   logic [1:0]        m_mux_id;
   logic [LB-1:0]     m_mux_len;
   logic [N-1:0]      busy_out;

   mmu_arbiter_wrr #(.N_CH(N), .REQ_BITS(RB), .LEN_LSB(LL), .LEN_BITS(LB), .W_BITS(WB), .MAX_OUT(MO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
      .cnfg_weight(cnfg_weight), .xfer_done(xfer_done),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
      .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready), .m_mux_id(m_mux_id),
      .m_mux_len(m_mux_len), .busy_out(busy_out)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int passes = 0;
   bit in_reset = 1'b1;

   int m_ptr, m_rem, m_cnt [N];
   bit m_hold, fr, fm;
   logic [RB-1:0] exp_req_q [$];
   int            exp_id_q [$];
   logic [LB-1:0] exp_len_q [$];

   int p_valid, p_rr, p_mr, p_done, p_wchg;
   logic [N-1:0] chan_mask, done_force;
   int gcnt [N];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic int decide();
      int g = -1;
      int w;
      bit free;
      bit el [N];
      free = (!fr || m_req_ready) && (!fm || m_mux_ready);
      for (int i = 0; i < N; i++) el[i] = s_req_valid[i] && (m_cnt[i] < MO);
      if (m_hold) begin
         if (!el[m_ptr]) begin
            m_ptr = (m_ptr + 1) % N;
            m_hold = 0;
         end else if (free) begin
            g = m_ptr;
            m_rem--;
            if (m_rem == 0) begin
               m_ptr = (m_ptr + 1) % N;
               m_hold = 0;
            end
         end
      end else if (free) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && el[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         if (g >= 0) begin
            w = int'(cnfg_weight[g*WB +: WB]);
            m_rem = (w == 0) ? 0 : w - 1;
            if (m_rem == 0) m_ptr = (g + 1) % N;
            else begin
               m_ptr = g;
               m_hold = 1;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (g == i && !(xfer_done[i] && m_cnt[i] > 0)) m_cnt[i]++;
         else if (g != i && xfer_done[i] && m_cnt[i] > 0) m_cnt[i]--;
      end
      fr = (g >= 0) || (fr && !m_req_ready);
      fm = (g >= 0) || (fm && !m_mux_ready);
      return g;
   endfunction

   task automatic step();
      int g;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_busy;
      logic [RB-1:0] gdata;
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin
         s_req_valid[i] = chan_mask[i] && ($urandom_range(99) < p_valid);
         s_req_data[i*RB +: RB] = {$urandom, $urandom, $urandom};
         xfer_done[i] = done_force[i] || ($urandom_range(99) < p_done);
         if ($urandom_range(99) < p_wchg) cnfg_weight[i*WB +: WB] = WB'($urandom_range(5));
      end
      m_req_ready = ($urandom_range(99) < p_rr);
      m_mux_ready = ($urandom_range(99) < p_mr);
      #1;
      exp_busy = '0;
      for (int i = 0; i < N; i++) exp_busy[i] = (m_cnt[i] != 0);
      check("busy_out", busy_out, exp_busy);
      g = decide();
      exp_rdy = '0;
      gdata = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         gdata = s_req_data[g*RB +: RB];
      end
      check("s_req_ready", s_req_ready, exp_rdy);
      for (int i = 0; i < N; i++) if (s_req_ready[i]) gcnt[i]++;
      @(posedge aclk);
      if (g >= 0) begin
         exp_req_q.push_back(gdata);
         exp_id_q.push_back(g);
         exp_len_q.push_back(gdata[LL +: LB]);
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic do_reset(input int n);
      in_reset = 1'b1;
      @(negedge aclk);
      aresetn = 1'b0;
      s_req_valid = '1;
      for (int c = 0; c < n; c++) begin
         #1;
         check("reset_ready", s_req_ready, '0);
         @(posedge aclk);
         #1;
         check("reset_outputs", {m_req_valid, m_mux_valid, m_mux_id, m_mux_len, busy_out}, '0);
         check("reset_data", m_req_data, '0);
         @(negedge aclk);
      end
      exp_req_q.delete();
      exp_id_q.delete();
      exp_len_q.delete();
      m_ptr = 0; m_rem = 0; m_hold = 0; fr = 0; fm = 0;
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         gcnt[i] = 0;
      end
      s_req_valid = '0;
      xfer_done = '0;
      aresetn = 1'b1;
      in_reset = 1'b0;
   endtask

   always @(negedge aclk) begin
      #2;
      if (!in_reset) begin
         check("m_req_valid", m_req_valid, exp_req_q.size() != 0);
         check("m_mux_valid", m_mux_valid, exp_mux_pending());
         if (m_req_valid && m_req_ready && exp_req_q.size() != 0)
            check("m_req_data", m_req_data, exp_req_q.pop_front());
         if (m_mux_valid && m_mux_ready && exp_id_q.size() != 0) begin
            check("m_mux_id", m_mux_id, exp_id_q.pop_front());
            check("m_mux_len", m_mux_len, exp_len_q.pop_front());
         end
      end
   end

   function automatic bit exp_mux_pending();
      return exp_id_q.size() != 0;
   endfunction

   task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
      cnfg_weight = {WB'(w3), WB'(w2), WB'(w1), WB'(w0)};
   endtask

   initial begin
      aresetn = 1'b0;
      s_req_valid = '1;
      s_req_data = '0;
      xfer_done = '0;
      m_req_ready = 1'b1;
      m_mux_ready = 1'b1;
      done_force = '0;
      chan_mask = '1;
      p_wchg = 0;
      set_weights(1, 1, 1, 1);

      // reset with all channels requesting, then round-robin at weight 1
      do_reset(3);
      p_valid = 100; p_rr = 100; p_mr = 100; p_done = 0;
      run(8);
      for (int i = 0; i < N; i++) check("rr_grants", gcnt[i], 2);

      // weights {3,1,1,1}
      do_reset(1);
      set_weights(3, 1, 1, 1);
      run(9);
      check("wrr_ch0", gcnt[0], 6);
      check("wrr_ch1", gcnt[1], 1);
      check("wrr_ch3", gcnt[3], 1);

      // credit ceiling on ch0, one credit returned
      do_reset(1);
      set_weights(1, 1, 1, 1);
      chan_mask = 4'b0001;
      run(15);
      check("credit_ceiling", gcnt[0], 8);
      done_force = 4'b0001;
      run(1);
      done_force = '0;
      run(6);
      check("credit_return", gcnt[0], 9);

      // grant and xfer_done together on ch2 at outcnt 5
      do_reset(1);
      chan_mask = 4'b0100;
      run(5);
      done_force = 4'b0100;
      run(1);
      done_force = '0;
      run(10);
      check("credit_simul", gcnt[2], 9);

      // mux sink blocked, req sink open
      do_reset(1);
      chan_mask = '1;
      p_mr = 0;
      run(6);
      check("mux_stall", gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3], 1);
      p_mr = 100;
      run(6);

      // randomized traffic, then reset while entries may be pending
      p_valid = 70; p_rr = 70; p_mr = 70; p_done = 30; p_wchg = 10;
      run(1500);
      p_rr = 20; p_mr = 20;
      run(20);
      do_reset(2);
      p_rr = 80; p_mr = 60; p_done = 15;
      run(1500);

      p_valid = 0; p_rr = 100; p_mr = 100; p_wchg = 0;
      run(5);
      check("drain_req", exp_req_q.size(), 0);
      check("drain_mux", exp_id_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
